// File: rtl/dmem_arb_pkg.sv
// dmem_arbiter shared types: FSM states, access sizes, byte masks,
// master indices and small access-decoding helpers.
package dmem_arb_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } size_e;

  localparam logic [3:0] BM_WORD = 4'b1111;
  localparam logic [3:0] BM_HALF = 4'b0011;
  localparam logic [3:0] BM_BYTE = 4'b0001;

  localparam int unsigned M_CORE = 0;
  localparam int unsigned M_DMA  = 1;

  // Size 11 is never legal; half needs even, word needs 4-byte alignment.
  function automatic logic is_misaligned(
    input logic [1:0] sz,
    input logic [1:0] off
  );
    logic m;
    m = 1'b1;
    unique case (1'b1)
      (sz == SZ_BYTE): m = 1'b0;
      (sz == SZ_HALF): m = off[0];
      (sz == SZ_WORD): m = |off;
      default:         m = 1'b1;
    endcase
    return m;
  endfunction

  function automatic logic [3:0] bmask_of(
    input logic [1:0] sz
  );
    logic [3:0] bm;
    bm = BM_WORD;
    unique case (1'b1)
      (sz == SZ_BYTE): bm = BM_BYTE;
      (sz == SZ_HALF): bm = BM_HALF;
      default:         bm = BM_WORD;
    endcase
    return bm;
  endfunction

endpackage

// File: rtl/dmem_arbiter_load_ext.sv
// dmem_load_ext: sign/zero extension of right-aligned
// memory read data according to access size.
module dmem_load_ext
  import dmem_arb_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic [1:0]    i_size,
  input  logic          i_unsigned,
  input  logic [DW-1:0] i_data,
  output logic [DW-1:0] o_data
);

  logic w_sb;
  logic w_sh;

  assign w_sb = ~i_unsigned & i_data[7];
  assign w_sh = ~i_unsigned & i_data[15];

  // widen byte/half loads, pass words through
  always_comb begin
    o_data = i_data;
    unique case (1'b1)
      (i_size == SZ_BYTE):
        o_data = {{(DW-8){w_sb}}, i_data[7:0]};
      (i_size == SZ_HALF):
        o_data = {{(DW-16){w_sh}}, i_data[15:0]};
      default:
        o_data = i_data;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-master data memory arbiter and access sequencer.
// Define DMEM_ARB_RR_EN for round-robin; otherwise the core has priority.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int AW = 11,
  parameter int DW = 32
) (
  input  logic                i_clk,
  input  logic                i_reset_n,
  input  logic [1:0]          i_req,
  input  logic [1:0]          i_we,
  input  logic [1:0][1:0]     i_size,
  input  logic [1:0]          i_unsigned,
  input  logic [1:0][AW-1:0]  i_addr,
  input  logic [1:0][DW-1:0]  i_wdata,
  output logic [1:0]          o_gnt,
  output logic [1:0]          o_rvalid,
  output logic [DW-1:0]       o_rdata,
  output logic                o_err,
  output logic [AW-1:0]       o_mem_addr,
  output logic [DW-1:0]       o_mem_wdata,
  output logic [3:0]          o_mem_bmask,
  output logic                o_mem_wren,
  input  logic [DW-1:0]       i_mem_rdata
);

  state_e         r_state;
  logic           r_win;
  logic           r_we;
  logic [1:0]     r_size;
  logic           r_uns;
  logic [AW-1:0]  r_addr;
  logic [DW-1:0]  r_wdata;
  logic           r_mis;
  logic [1:0]     r_rvalid;
  logic [DW-1:0]  r_rdata;
  logic           r_err;

  logic           w_idle;
  logic           w_acc;
  logic           w_take;
  logic           w_win;
  logic           w_wr;
  logic [DW-1:0]  w_ext;

  assign w_idle = (r_state == IDLE);
  assign w_acc  = (r_state == ACCESS);
  // gated by reset so no grant is shown while the block is held in reset
  assign w_take = w_idle & (|i_req) & i_reset_n;

`ifdef DMEM_ARB_RR_EN
  logic r_last;

  // lone requester wins; on a tie the master not granted last wins
  always_comb begin
    w_win = 1'b0;
    unique case (1'b1)
      (i_req == 2'b01): w_win = 1'b0;
      (i_req == 2'b10): w_win = 1'b1;
      (i_req == 2'b11): w_win = ~r_last;
      default:          w_win = 1'b0;
    endcase
  end

  // last-grant pointer; reset value lets the core win the first tie
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_last <= 1'b1;
    end else if (w_take) begin
      r_last <= w_win;
    end
  end
`else
  // fixed priority: the DMA wins only while the core is silent
  assign w_win = ~i_req[M_CORE];
`endif

  assign o_gnt = w_take ? (w_win ? 2'b10 : 2'b01) : 2'b00;

  // two-state sequencer: grant in IDLE, one memory cycle in ACCESS
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= IDLE;
    end else if (w_take) begin
      r_state <= ACCESS;
    end else if (w_acc) begin
      r_state <= IDLE;
    end
  end

  // capture the winner's request so it may change it from the next cycle
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_win   <= 1'b0;
      r_we    <= 1'b0;
      r_size  <= SZ_WORD;
      r_uns   <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_mis   <= 1'b0;
    end else if (w_take) begin
      r_win   <= w_win;
      r_we    <= i_we[w_win];
      r_size  <= i_size[w_win];
      r_uns   <= i_unsigned[w_win];
      r_addr  <= i_addr[w_win];
      r_wdata <= i_wdata[w_win];
      r_mis   <= is_misaligned(i_size[w_win],
                               i_addr[w_win][1:0]);
    end
  end

  dmem_load_ext #(
    .DW (DW)
  ) u_ext (
    .i_size     (r_size),
    .i_unsigned (r_uns),
    .i_data     (i_mem_rdata),
    .o_data     (w_ext)
  );

  // respond to the access winner one cycle after the memory cycle
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_rvalid <= 2'b00;
      r_rdata  <= '0;
      r_err    <= 1'b0;
    end else if (w_acc) begin
      r_rvalid <= r_win ? 2'b10 : 2'b01;
      r_err    <= r_mis;
      r_rdata  <= (r_mis | r_we) ? '0 : w_ext;
    end else begin
      r_rvalid <= 2'b00;
    end
  end

  assign o_rvalid = r_rvalid;
  assign o_rdata  = r_rdata;
  assign o_err    = r_err;

  // async reset clears r_state, so a write in flight drops at once
  assign w_wr        = w_acc & r_we & ~r_mis;
  assign o_mem_wren  = w_wr;
  assign o_mem_addr  = w_acc ? r_addr : '0;
  assign o_mem_wdata = w_acc ? r_wdata : '0;
  assign o_mem_bmask = w_acc ? bmask_of(r_size) : BM_WORD;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed and random accesses against a byte-array
// reference of the data memory and a grant/response timing model.
module tb_dmem_arbiter;

  localparam int AW = 11;
  localparam int DW = 32;

  logic               i_clk = 1'b0;
  logic               i_reset_n;
  logic [1:0]         i_req;
  logic [1:0]         i_we;
  logic [1:0][1:0]    i_size;
  logic [1:0]         i_unsigned;
  logic [1:0][AW-1:0] i_addr;
  logic [1:0][DW-1:0] i_wdata;
  logic [1:0]         o_gnt;
  logic [1:0]         o_rvalid;
  logic [DW-1:0]      o_rdata;
  logic               o_err;
  logic [AW-1:0]      o_mem_addr;
  logic [DW-1:0]      o_mem_wdata;
  logic [3:0]         o_mem_bmask;
  logic               o_mem_wren;
  logic [DW-1:0]      i_mem_rdata;

  always #5 i_clk = ~i_clk;

  dmem_arbiter #(.AW(AW), .DW(DW)) dut (
    .i_clk       (i_clk),
    .i_reset_n   (i_reset_n),
    .i_req       (i_req),
    .i_we        (i_we),
    .i_size      (i_size),
    .i_unsigned  (i_unsigned),
    .i_addr      (i_addr),
    .i_wdata     (i_wdata),
    .o_gnt       (o_gnt),
    .o_rvalid    (o_rvalid),
    .o_rdata     (o_rdata),
    .o_err       (o_err),
    .o_mem_addr  (o_mem_addr),
    .o_mem_wdata (o_mem_wdata),
    .o_mem_bmask (o_mem_bmask),
    .o_mem_wren  (o_mem_wren),
    .i_mem_rdata (i_mem_rdata)
  );

  // memory device: word array, byte lanes, read shifted by addr[1:0]
  logic [31:0] mem [512];
  logic        mem_rdy = 1'b0;
  logic [3:0]  w_lane;
  logic [31:0] w_wsh;

  assign w_lane = o_mem_bmask << o_mem_addr[1:0];
  assign w_wsh  = o_mem_wdata << {o_mem_addr[1:0], 3'b000};

  always_comb begin
    i_mem_rdata = '0;
    if (!o_mem_wren)
      i_mem_rdata = mem[o_mem_addr[10:2]] >> {o_mem_addr[1:0], 3'b000};
  end

  always @(posedge i_clk) begin
    if (!mem_rdy) begin
      for (int i = 0; i < 512; i++) mem[i] <= '0;
      mem[4] <= 32'h8000_00F1;
    end else if (o_mem_wren) begin
      for (int b = 0; b < 4; b++)
        if (w_lane[b]) mem[o_mem_addr[10:2]][8*b +: 8] <= w_wsh[8*b +: 8];
    end
  end

  // reference model state
  logic [7:0]  ref_mem [2048];
  bit          acc_v;
  int          a_m, a_sz, a_ad;
  bit          a_we, a_un;
  logic [31:0] a_wd;
  bit          rsp_v, rsp_e, rsp_dchk;
  int          rsp_m;
  logic [31:0] rsp_d;
  int          last;
  bit [1:0]    granted;
  bit [1:0]    hold;
  bit          rnd;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic bit bad_access(input int sz, input int ad);
    if (sz == 3) return 1'b1;
    return (ad % (1 << sz)) != 0;
  endfunction

  function automatic logic [31:0] load_val(input int sz, input bit un,
                                           input int ad);
    longint v;
    int     n;
    n = 1 << sz;
    v = 0;
    for (int i = 0; i < n; i++) v += longint'(ref_mem[ad+i]) << (8*i);
    if (!un && v >= (longint'(1) << (8*n-1))) v -= (longint'(1) << (8*n));
    return v[31:0];
  endfunction

  task automatic new_req(input int m);
    i_req[m]      = 1'b1;
    i_we[m]       = 1'($urandom % 2);
    i_size[m]     = 2'($urandom % 4);
    i_unsigned[m] = 1'($urandom % 2);
    i_addr[m]     = 11'($urandom_range(0, 63));
    i_wdata[m]    = $urandom;
  endtask

  // after the clock edge: check response and memory cycle, move masters
  task automatic cycle_a(output bit busy);
    bit   mis;
    int   n;
    logic [1:0] eg;
    @(posedge i_clk);
    #1;
    if (rsp_v) begin
      eg = (rsp_m == 1) ? 2'b10 : 2'b01;
      check("rvalid", 32'(o_rvalid), 32'(eg));
      check("err", 32'(o_err), 32'(rsp_e));
      if (rsp_dchk) check("rdata", o_rdata, rsp_d);
    end else begin
      check("rvalid_quiet", 32'(o_rvalid), 32'd0);
    end
    rsp_v = 1'b0;
    busy  = acc_v;
    if (acc_v) begin
      mis = bad_access(a_sz, a_ad);
      check("wren", 32'(o_mem_wren), 32'(a_we && !mis));
      if (!mis) begin
        n = 1 << a_sz;
        check("bmask", 32'(o_mem_bmask), 32'((1 << n) - 1));
        check("maddr", 32'(o_mem_addr), 32'(a_ad));
        if (a_we)
          for (int i = 0; i < n; i++) ref_mem[a_ad+i] = a_wd[8*i +: 8];
      end
      rsp_v    = 1'b1;
      rsp_m    = a_m;
      rsp_e    = mis;
      rsp_dchk = mis || !a_we;
      rsp_d    = mis ? 32'd0 : load_val(a_sz, a_un, a_ad);
      acc_v    = 1'b0;
    end else begin
      check("idle_wren", 32'(o_mem_wren), 32'd0);
      check("idle_bmask", 32'(o_mem_bmask), 32'hF);
      check("idle_addr", 32'(o_mem_addr), 32'd0);
    end
    for (int m = 0; m < 2; m++) begin
      if (granted[m]) begin
        granted[m] = 1'b0;
        if (!hold[m]) i_req[m] = 1'b0;
      end
    end
    if (rnd)
      for (int m = 0; m < 2; m++)
        if (!i_req[m] && ($urandom % 2) == 0) new_req(m);
  endtask

  // settled inputs: predict the grant from the arbitration rules
  task automatic cycle_b(input bit busy);
    int w;
    logic [1:0] eg;
    #1;
    eg = 2'b00;
    if (!busy && i_req != 2'b00) begin
      if (i_req == 2'b11) begin
`ifdef DMEM_ARB_RR_EN
        w = 1 - last;
`else
        w = 0;
`endif
      end else begin
        w = i_req[1] ? 1 : 0;
      end
      eg         = (w == 1) ? 2'b10 : 2'b01;
      granted[w] = 1'b1;
      last       = w;
      acc_v      = 1'b1;
      a_m        = w;
      a_we       = i_we[w];
      a_sz       = int'(i_size[w]);
      a_un       = i_unsigned[w];
      a_ad       = int'(i_addr[w]);
      a_wd       = i_wdata[w];
    end
    check("gnt", 32'(o_gnt), 32'(eg));
  endtask

  task automatic cycle();
    bit busy;
    cycle_a(busy);
    cycle_b(busy);
  endtask

  task automatic issue(input int m, input bit we, input int sz,
                       input bit un, input int ad, input logic [31:0] wd);
    bit busy;
    int k;
    cycle_a(busy);
    i_req[m]      = 1'b1;
    i_we[m]       = we;
    i_size[m]     = 2'(sz);
    i_unsigned[m] = un;
    i_addr[m]     = 11'(ad);
    i_wdata[m]    = wd;
    cycle_b(busy);
    k = 0;
    while (!granted[m] && k < 10) begin
      cycle();
      k++;
    end
    if (!granted[m]) check("gnt_timeout", 32'd0, 32'd1);
    repeat (2) cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit busy;
    for (int i = 0; i < 2048; i++) ref_mem[i] = 8'h00;
    ref_mem[16] = 8'hF1;
    ref_mem[19] = 8'h80;
    acc_v = 0; rsp_v = 0; granted = 0; hold = 0; rnd = 0; last = 1;
    i_reset_n  = 1'b0;
    i_req      = 2'b11;
    i_we       = '0;
    i_size     = '0;
    i_unsigned = '0;
    i_addr     = '0;
    i_wdata    = '0;
    #3;
    check("rst_gnt", 32'(o_gnt), 32'd0);
    check("rst_rvalid", 32'(o_rvalid), 32'd0);
    check("rst_rdata", o_rdata, 32'd0);
    check("rst_err", 32'(o_err), 32'd0);
    check("rst_wren", 32'(o_mem_wren), 32'd0);
    check("rst_maddr", 32'(o_mem_addr), 32'd0);
    check("rst_wdata", o_mem_wdata, 32'd0);
    check("rst_bmask", 32'(o_mem_bmask), 32'hF);
    i_req = 2'b00;
    @(posedge i_clk);
    @(posedge i_clk);
    #1;
    mem_rdy   = 1'b1;
    i_reset_n = 1'b1;

    issue(0, 0, 2, 0, 'h010, 32'h0);
    issue(1, 1, 0, 0, 'h013, 32'h0000_00A5);
    issue(0, 0, 0, 0, 'h013, 32'h0);
    issue(0, 0, 0, 1, 'h013, 32'h0);
    issue(0, 0, 1, 0, 'h003, 32'h0);
    issue(0, 1, 2, 0, 'h002, 32'hDEAD_BEEF);
    issue(0, 0, 2, 0, 'h000, 32'h0);
    issue(0, 0, 3, 0, 'h000, 32'h0);
    issue(1, 0, 2, 0, 'h010, 32'h0);

    cycle_a(busy);
    hold = 2'b11;
    i_req = 2'b11;
    i_we = 2'b00;
    i_size[0] = 2'b10; i_size[1] = 2'b00;
    i_unsigned = 2'b01;
    i_addr[0] = 11'h010; i_addr[1] = 11'h013;
    cycle_b(busy);
    repeat (8) cycle();
    hold = 2'b00;
    repeat (8) cycle();

    cycle_a(busy);
    i_req[0] = 1'b1; i_we[0] = 1'b1; i_size[0] = 2'b10;
    i_addr[0] = 11'h020; i_wdata[0] = 32'h1234_5678;
    cycle_b(busy);
    @(posedge i_clk);
    #1;
    check("rst_acc_wren", 32'(o_mem_wren), 32'd1);
    granted = 0; i_req = 2'b00;
    i_reset_n = 1'b0;
    #1;
    check("rst_mid_wren", 32'(o_mem_wren), 32'd0);
    @(posedge i_clk);
    #1;
    check("rst_mid_rvalid", 32'(o_rvalid), 32'd0);
    i_reset_n = 1'b1;
    acc_v = 0; rsp_v = 0; last = 1;
    issue(0, 0, 2, 0, 'h020, 32'h0);

    rnd = 1'b1;
    repeat (600) cycle();
    rnd = 1'b0;
    repeat (10) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-master arbiter and access sequencer for the 2 KB data memory (512 × 32-bit words, 11-bit byte address). It shares the single memory port between the core load/store unit (master 0) and the DMA/debug port (master 1). For each access it does four things: translates the access size into the memory's size-encoded byte mask, checks alignment, sequences one write or read cycle, and returns registered, sign- or zero-extended load data with a per-master response strobe.

## Interface
Parameters:
- AW, 11, byte address width
- DW, 32, data width

Ports (index [m] = master m, 0 = core, 1 = DMA):
- i_clk  in  1  clock; all state updates on rising edge
- i_reset_n  in  1  asynchronous, active-low reset
- i_req  in  [1:0]  access request per master; held until granted
- i_we  in  [1:0]  1 = store, 0 = load
- i_size  in  [1:0][1:0]  00 byte, 01 half, 10 word, 11 illegal
- i_unsigned  in  [1:0]  load zero-extend (1) / sign-extend (0)
- i_addr  in  [1:0][AW-1:0]  byte address
- i_wdata  in  [1:0][DW-1:0]  store data, right-aligned (byte in [7:0], half in [15:0])
- o_gnt  out  [1:0]  one-hot, combinational; request accepted this cycle
- o_rvalid  out  [1:0]  one-cycle response strobe; also acks stores
- o_rdata  out  DW  load result, shared; valid with o_rvalid
- o_err  out  1  misaligned/illegal-size flag, valid with o_rvalid
- o_mem_addr  out  AW  to memory
- o_mem_wdata  out  DW  to memory, right-aligned
- o_mem_bmask  out  4  1111 word, 0011 half, 0001 byte
- o_mem_wren  out  1  memory write enable
- i_mem_rdata  in  DW  combinational memory read data, already shifted right by addr[1:0]; reads 0 while o_mem_wren=1

## Operation
- FSM states: IDLE, ACCESS.
- IDLE:
  - If any i_req is set, pick a winner and assert o_gnt[winner] combinationally.
  - Latch that master's we/size/unsigned/addr/wdata and whether the access is misaligned.
  - Go to ACCESS.
  - With no request, stay in IDLE.
- Misaligned: half with addr[0]=1; word with addr[1:0]≠00; size 11 in any case.
- ACCESS, legal store: o_mem_wren=1 for exactly this cycle; o_mem_addr, o_mem_wdata and o_mem_bmask come from the latched request.
- ACCESS, legal load: o_mem_wren=0. At the cycle end, register the extended i_mem_rdata:
  - byte: bit 7 extended to 32 bits
  - half: bit 15 extended to 32 bits
  - word: passed unchanged
  - zero-extended instead of sign-extended when unsigned is set
- ACCESS, misaligned: no memory side effects (o_mem_wren=0); o_rdata=0 and o_err=1.
- ACCESS always returns to IDLE. o_rvalid[winner] pulses in the following cycle.
- Outside ACCESS, memory outputs are held at o_mem_wren=0, o_mem_bmask=1111 and address 0.
- Arbitration: round-robin (see Configuration). A last-grant pointer is updated on each grant; the master not granted last wins a tie. The pointer resets to favour master 0.

## Timing
- Cycle N: req sampled, o_gnt pulses, and the request is latched. The master may change its fields or drop req from N+1.
- Cycle N+1: ACCESS, the memory cycle.
- Cycle N+2: o_rvalid, o_rdata and o_err are registered outputs. The FSM is back in IDLE and may grant again in N+2. Throughput is one access per 2 cycles.
- The core's response at N+2 and a new grant at N+2 may coincide. The response goes to the previous winner only.
- Reset values: state IDLE; o_gnt=0, o_rvalid=0, o_rdata=0, o_err=0; o_mem_wren=0, o_mem_addr=0, o_mem_wdata=0, o_mem_bmask=1111.
- Reset asserted mid-ACCESS: o_mem_wren drops immediately. No response is issued, and the aborted requester must reissue.
- A requester holding req after its grant gets a new grant in N+2 (back-to-back), subject to arbitration.

## Configuration
- DMEM_ARB_RR_EN defined: round-robin arbitration as in Operation.
- DMEM_ARB_RR_EN undefined: fixed priority, master 0 always wins a tie, and the last-grant pointer is not implemented.

## Structure
- dmem_arb_pkg holds:
  - state enum (IDLE, ACCESS)
  - size enum (SZ_BYTE, SZ_HALF, SZ_WORD)
  - bmask constants (BM_WORD=1111, BM_HALF=0011, BM_BYTE=0001)
  - master index constants
- One sub-module, dmem_load_ext: combinational size/unsigned-driven extension of i_mem_rdata.

## Test plan
- Core load word, addr 0x010, memory word 0x8000_00F1 -> gnt[0] in N; ACCESS in N+1 with bmask 1111, wren 0; rvalid[0] in N+2 with rdata 0x8000_00F1 and err 0.
- DMA store byte 0xA5 at 0x013, then core signed byte load at 0x013 -> store: wren for one cycle, bmask 0001, wdata[7:0]=A5. Load: rdata 0xFFFF_FFA5. Repeat the load with unsigned=1 -> 0x0000_00A5.
- Both masters request continuously (RR_EN defined) -> grants alternate 0,1,0,1 every 2 cycles. With the macro undefined, master 0 is granted every time.
- Core half load at 0x003 (misaligned), then word store at 0x002 -> o_err=1, rdata 0, and o_mem_wren never asserted. Memory contents are unchanged on readback.
- Reset (i_reset_n=0) asserted during ACCESS of a store -> o_mem_wren=0 and no rvalid. After release, the first request is granted normally.
- Illegal size 11 load at 0x000 -> err=1, rvalid pulse, rdata 0.
